wb_reg_slave: RTL and testbench

Pipelined Wishbone B4 slave exposing a bank of 32-bit read/write registers, with a programmable number of wait states and an error response for unmapped addresses. It is the responder at the far end of the UART-to-Wishbone bridge's bus master. It gives the bridge a known, cycle-predictable target for bring-up and for regression of the master's stall, ack and err handling.

---
 rtl/wb_reg_slave.sv | 256 +++++++++++++++++++++++++
 tb/tb_wb_reg_slave.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_slave.sv
// ---------------------------------------------------------------------------
// wb_reg_slave
//
// Pipelined Wishbone B4 slave that exposes NREGS 32-bit read/write registers.
// Every transaction takes a fixed number of cycles, so it is a predictable
// target for exercising a bus master's stall, ack and err handling.
//
// Only one request is outstanding at a time. A request is accepted in IDLE.
// The FSM then spends WAIT_STATES cycles in WAIT and one cycle in RESP.
// The ack or err pulse is presented in RESP.
//
// Parameters:
//   NREGS        number of 32-bit registers (1..1024)
//   WAIT_STATES  idle cycles between acceptance and response (0..15)
//
// Compile-time option:
//   WB_SLAVE_ERR_EN  when defined, unmapped addresses complete with o_wb_err.
//                    When undefined, o_wb_err is tied low. Unmapped accesses
//                    then ack normally: reads return zero and writes are
//                    dropped.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_wb_cyc    bus cycle in progress
//   i_wb_stb    request strobe
//   i_wb_we     1 = write, 0 = read
//   i_wb_addr   30-bit word address
//   i_wb_data   write data
//   i_wb_sel    byte enables (bit n covers data[8n+7:8n])
//   o_wb_stall  request not accepted this cycle
//   o_wb_ack    single-cycle successful completion
//   o_wb_err    single-cycle error completion
//   o_wb_data   read data, valid while o_wb_ack is high, held otherwise
// ---------------------------------------------------------------------------
module wb_reg_slave #(
  parameter int NREGS       = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;

  // Request captured at acceptance.
  logic        r_we;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;

  logic [31:0] r_regs [NREGS];

  logic        r_stall;
  logic        r_ack;
  logic [31:0] r_rdata;
`ifdef WB_SLAVE_ERR_EN
  logic        r_err;
  logic        w_err_next;
`endif

  logic        w_accept;
  logic        w_we;
  logic [29:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_sel;
  logic        w_in_range;
  logic [IW-1:0] w_idx;

  logic        w_stall_next;
  logic        w_ack_next;
  logic        w_wr_en;
  logic        w_rd_load;
  logic [31:0] w_rd_val;

  assign w_accept = (r_state == ST_IDLE) && i_wb_cyc && i_wb_stb;

  // With WAIT_STATES = 0, RESP is entered on the acceptance edge itself.
  // The live bus values must be used then, because the captured copy is not
  // yet loaded. In every other case, the captured copy is the request.
  assign w_we    = (r_state == ST_IDLE) ? i_wb_we   : r_we;
  assign w_addr  = (r_state == ST_IDLE) ? i_wb_addr : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? i_wb_data : r_wdata;
  assign w_sel   = (r_state == ST_IDLE) ? i_wb_sel  : r_sel;

  // Full 30-bit compare, so addresses above NREGS never alias onto a register.
  assign w_in_range = (w_addr < 30'(NREGS));
  assign w_idx      = w_addr[IW-1:0];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        // When the master drops cyc, the pending request is abandoned.
        if (!i_wb_cyc) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output / datapath control
  // Everything is decided on the edge that enters RESP. The registered ack,
  // err and data, and any register write, are therefore visible together in
  // the response cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    w_stall_next = (w_state_next != ST_IDLE);
    w_ack_next   = 1'b0;
`ifdef WB_SLAVE_ERR_EN
    w_err_next   = 1'b0;
`endif
    w_wr_en      = 1'b0;
    w_rd_load    = 1'b0;
    w_rd_val     = r_rdata;
    if (w_state_next == ST_RESP) begin
      if (w_in_range) begin
        w_ack_next = 1'b1;
        w_wr_en    = w_we;
        if (!w_we) begin
          w_rd_load = 1'b1;
          w_rd_val  = r_regs[w_idx];
        end
      end else begin
`ifdef WB_SLAVE_ERR_EN
        w_err_next = 1'b1;
`else
        w_ack_next = 1'b1;
        if (!w_we) begin
          w_rd_load = 1'b1;
          w_rd_val  = 32'h0000_0000;
        end
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request capture and wait counter
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 30'd0;
      r_wdata <= 32'd0;
      r_sel   <= 4'd0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_we    <= i_wb_we;
        r_addr  <= i_wb_addr;
        r_wdata <= i_wb_data;
        r_sel   <= i_wb_sel;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register bank with byte enables
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_sel[b]) begin
          r_regs[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered bus outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
`ifdef WB_SLAVE_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_stall <= w_stall_next;
      r_ack   <= w_ack_next;
`ifdef WB_SLAVE_ERR_EN
      r_err   <= w_err_next;
`endif
      if (w_rd_load) begin
        r_rdata <= w_rd_val;
      end
    end
  end

  assign o_wb_stall = r_stall;
  assign o_wb_data  = r_rdata;
  // If the master drops cyc during the response cycle, the response is
  // already registered. Gating it with cyc suppresses that response.
  assign o_wb_ack   = r_ack & i_wb_cyc;
`ifdef WB_SLAVE_ERR_EN
  assign o_wb_err   = r_err & i_wb_cyc;
`else
  assign o_wb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_reg_slave
//
// Bench for wb_reg_slave.
//
// Two instances share one bus:
//   dut   WAIT_STATES = 2
//   dut0  WAIT_STATES = 0
//
// The bench drives single transactions from a vector table, then applies
// hand-written sequences for abort, back-to-back and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_wb_reg_slave;

  localparam int WS = 2;
`ifdef WB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall, ack, err;
  logic [31:0] rdata;
  logic        stall0, ack0, err0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  wb_reg_slave #(.NREGS(16), .WAIT_STATES(WS)) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdata)
  );

  wb_reg_slave #(.NREGS(16), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall0), .o_wb_ack(ack0), .o_wb_err(err0), .o_wb_data(rdata0)
  );

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        unmapped;
    logic [31:0] exp;     // expected read data (reads only)
  } vec_t;

  vec_t vecs[18];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the bus idle. Runs one transaction on dut.
  task automatic txn(input logic t_we, input logic [29:0] t_addr,
                     input logic [31:0] t_data, input logic [3:0] t_sel,
                     input logic t_unm, input logic [31:0] t_exp, input string nm);
    int lat, nstall, k;
    logic g_ack, g_err, exp_err, chk_data;
    logic [31:0] g_data;
    exp_err  = t_unm && ERR_EN;
    chk_data = !t_we && !exp_err;
    chk({nm, " stall@accept"}, {31'b0, stall}, 32'd0);
    cyc = 1'b1; stb = 1'b1; we = t_we; addr = t_addr; wdata = t_data; sel = t_sel;
    @(negedge clk);
    stb = 1'b0;
    lat = 0; nstall = 0; g_ack = 1'b0; g_err = 1'b0; g_data = 32'd0; k = 1;
    while (lat == 0 && k <= 20) begin
      if (stall) nstall++;
      if (ack || err) begin
        lat = k; g_ack = ack; g_err = err; g_data = rdata;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'(WS + 1));
    chk({nm, " ack"}, {31'b0, g_ack}, {31'b0, !exp_err});
    chk({nm, " err"}, {31'b0, g_err}, {31'b0, exp_err});
    chk({nm, " stall cycles"}, 32'(nstall), 32'(WS + 1));
    if (chk_data) chk({nm, " rdata"}, g_data, t_exp);
    @(negedge clk);
    chk({nm, " single pulse"}, {30'b0, ack, err}, 32'd0);
    chk({nm, " stall after"}, {31'b0, stall}, 32'd0);
    if (chk_data) chk({nm, " rdata hold"}, rdata, t_exp);
    cyc = 1'b0;
    $display("txn %s we=%0b addr=%h wdata=%h sel=%h -> ack=%0b err=%0b lat=%0d rdata=%h",
             nm, t_we, t_addr, t_data, t_sel, g_ack, g_err, lat, g_data);
  endtask

  logic [29:0] b_addr[4];
  logic [31:0] b_exp[4];

  initial begin
    vecs[0]  = '{1'b0, 30'd5,          32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 30'd5,          32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 30'd5,          32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 30'd3,          32'h1122_3344, 4'hF, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 30'd3,          32'hAABB_CCDD, 4'h5, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 30'd3,          32'h0,         4'hF, 1'b0, 32'h11BB_33DD};
    vecs[6]  = '{1'b0, 30'd16,         32'h0,         4'hF, 1'b1, 32'h0000_0000};
    vecs[7]  = '{1'b1, 30'd16,         32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 30'd21,         32'hCAFE_F00D, 4'hF, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 30'h2000_0005,  32'h0102_0304, 4'hF, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 30'd5,          32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
    vecs[11] = '{1'b0, 30'd0,          32'h0,         4'hF, 1'b0, 32'h0000_0000};
    vecs[12] = '{1'b1, 30'd15,         32'h55AA_55AA, 4'h0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 30'd15,         32'h0,         4'hF, 1'b0, 32'h0000_0000};
    vecs[14] = '{1'b1, 30'd15,         32'h8765_4321, 4'h8, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 30'd15,         32'h0,         4'hF, 1'b0, 32'h8700_0000};
    vecs[16] = '{1'b1, 30'd2,          32'h0BAD_CAFE, 4'hF, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 30'h3FFF_FFFF,  32'h0,         4'hF, 1'b1, 32'h0000_0000};
    b_addr[0] = 30'd5;  b_exp[0] = 32'hDEAD_BEEF;
    b_addr[1] = 30'd3;  b_exp[1] = 32'h11BB_33DD;
    b_addr[2] = 30'd15; b_exp[2] = 32'h8700_0000;
    b_addr[3] = 30'd0;  b_exp[3] = 32'h0000_0000;

    // Reset state
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = 30'd0; wdata = 32'd0; sel = 4'h0;
    @(negedge clk); @(negedge clk);
    chk("reset stall", {31'b0, stall}, 32'd0);
    chk("reset ack/err", {30'b0, ack, err}, 32'd0);
    chk("reset data", rdata, 32'd0);
    chk("reset stall0", {31'b0, stall0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single transactions
    for (int i = 0; i < 18; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel,
          vecs[i].unmapped, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Abort in WAIT: cyc dropped at T+1, write to reg 2 is discarded
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd2; wdata = 32'h1234_5678; sel = 4'hF;
    @(negedge clk);
    chk("abort stall T+1", {31'b0, stall}, 32'd1);
    chk("abort ack/err T+1", {30'b0, ack, err}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("abort ack/err T+2", {30'b0, ack, err}, 32'd0);
    $display("txn abort-wait write reg2 12345678 dropped at T+1");
    txn(1'b0, 30'd2, 32'h0, 4'hF, 1'b0, 32'h0BAD_CAFE, "abort-readback");

    // Abort in RESP: the registered ack is masked as soon as cyc falls
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd4; wdata = 32'h4444_4444; sel = 4'hF;
    @(negedge clk); stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("resp-abort ack before drop", {31'b0, ack}, 32'd1);
    cyc = 1'b0;
    #1;
    chk("resp-abort ack masked", {30'b0, ack, err}, 32'd0);
    @(negedge clk);
    chk("resp-abort stall after", {31'b0, stall}, 32'd0);
    $display("txn abort-resp write reg4 ack masked by cyc");

    // Back-to-back reads on the zero-wait instance, stb held high
    for (int c = 0; c <= 8; c++) begin
      chk($sformatf("b2b stall c%0d", c), {31'b0, stall0}, 32'(c % 2));
      chk($sformatf("b2b ack c%0d", c), {31'b0, ack0}, 32'(c % 2));
      chk($sformatf("b2b err c%0d", c), {31'b0, err0}, 32'd0);
      if (c % 2 == 1) begin
        chk($sformatf("b2b rdata c%0d", c), rdata0, b_exp[c/2]);
        $display("txn b2b read addr=%h -> ack=%0b at T+%0d rdata=%h",
                 b_addr[c/2], ack0, c, rdata0);
      end
      if (c % 2 == 0 && c < 8) begin
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = b_addr[c/2];
      end
      if (c == 7) begin
        cyc = 1'b0; stb = 1'b0;
      end
      @(negedge clk);
    end

    // Asynchronous reset in the middle of WAIT
    txn(1'b0, 30'd5, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, "pre-reset");
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd5; wdata = 32'hFFFF_FFFF; sel = 4'hF;
    @(negedge clk); stb = 1'b0;
    chk("mid-wait stall", {31'b0, stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset stall", {31'b0, stall}, 32'd0);
    chk("async reset ack/err", {30'b0, ack, err}, 32'd0);
    chk("async reset data", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0;
    $display("txn async-reset during WAIT");
    @(negedge clk);
    txn(1'b0, 30'd5,  32'h0, 4'hF, 1'b0, 32'h0, "post-reset r5");
    txn(1'b0, 30'd3,  32'h0, 4'hF, 1'b0, 32'h0, "post-reset r3");
    txn(1'b0, 30'd15, 32'h0, 4'hF, 1'b0, 32'h0, "post-reset r15");
    txn(1'b0, 30'd2,  32'h0, 4'hF, 1'b0, 32'h0, "post-reset r2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
